// File: rtl/ucie_loopback_seq.sv
// Loopback self-test sequencer: fills the ingress buffer with an LFSR pattern, launches one pass,
// then drains the egress buffer and compares every word against the regenerated pattern.
module ucie_loopback_seq #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned PTR_W  = 5,
  parameter int unsigned TO_W   = 16
) (
  input  logic              i_hclk,
  input  logic              i_hreset_n,
  input  logic              i_start,
  input  logic [PTR_W:0]    i_num_words,
  input  logic [DWIDTH-1:0] i_seed,
  input  logic [TO_W-1:0]   i_timeout,
  output logic [DWIDTH-1:0] o_ig_wdata,
  output logic              o_ig_wdata_en,
  output logic              o_ig_wdata_upd,
  output logic              o_ig_wdata_clr,
  output logic [PTR_W-1:0]  o_ig_start_ptr,
  output logic [PTR_W-1:0]  o_ig_stop_ptr,
  output logic              o_ig_load_ptr,
  input  logic              i_ig_write_done,
  input  logic              i_ig_full,
  output logic              o_eg_rdata_clr,
  output logic              o_eg_rdata_en,
  output logic              o_eg_rdata_upd,
  input  logic [DWIDTH-1:0] i_eg_rdata,
  input  logic              i_eg_read_done,
  input  logic              i_eg_empty,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_pass,
  output logic [PTR_W:0]    o_err_cnt,
  output logic [PTR_W:0]    o_first_err_idx,
  output logic              o_timeout
);

  localparam int unsigned NW = PTR_W + 1;
  localparam logic [NW-1:0] DEPTH = NW'(1) << PTR_W;

  typedef enum logic [3:0] {
    StIdle, StClr, StLoad, StWrWait, StLaunch, StRdReq, StRdWait, StDone, StFail
  } state_e;

  state_e            r_state;
  logic [DWIDTH-1:0] r_lfsr;
  logic [DWIDTH-1:0] r_seed;
  logic [NW-1:0]     r_num;
  logic [NW-1:0]     r_cnt;
  logic [TO_W-1:0]   r_to;
  logic [TO_W-1:0]   r_wait;

  logic [DWIDTH-1:0] w_lfsr_nxt;
  logic [DWIDTH-1:0] w_seed;
  logic [NW-1:0]     w_num;
  logic [NW-1:0]     w_num_m1;
  logic [NW-1:0]     w_cnt_inc;
  logic [NW-1:0]     w_err_inc;
  logic [NW-1:0]     w_err_nxt;
  logic              w_last;
  logic              w_start;
  logic              w_mismatch;
  logic              w_wait_hit;
  logic              w_unused;

  assign w_lfsr_nxt = {r_lfsr[DWIDTH-2:0], r_lfsr[31] ^ r_lfsr[21] ^ r_lfsr[1] ^ r_lfsr[0]};
  assign w_seed     = (i_seed == '0) ? DWIDTH'(1) : i_seed;
  assign w_num      = (i_num_words == '0)   ? NW'(1) :
                      (i_num_words > DEPTH) ? DEPTH  : i_num_words;
  assign w_num_m1   = r_num - NW'(1);
  assign w_cnt_inc  = r_cnt + NW'(1);
  assign w_last     = (w_cnt_inc == r_num);
  assign w_start    = i_start && (r_state inside {StIdle, StDone, StFail});
  assign w_mismatch = (i_eg_rdata != r_lfsr);
  assign w_err_inc  = (o_err_cnt == '1) ? o_err_cnt : o_err_cnt + NW'(1);
  assign w_err_nxt  = w_mismatch ? w_err_inc : o_err_cnt;
  // A done strobe in the same cycle takes priority, so this is only consulted when none arrived.
  assign w_wait_hit = (r_to != '0) && (r_wait == r_to - TO_W'(1));
  assign w_unused   = i_eg_empty;

  // Outputs are registered on the edge that enters a state, so they are valid during that state.
  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      r_state         <= StIdle;
      r_lfsr          <= DWIDTH'(1);
      r_seed          <= '0;
      r_num           <= '0;
      r_cnt           <= '0;
      r_to            <= '0;
      r_wait          <= '0;
      o_ig_wdata      <= '0;
      o_ig_wdata_en   <= 1'b0;
      o_ig_wdata_upd  <= 1'b0;
      o_ig_wdata_clr  <= 1'b0;
      o_ig_start_ptr  <= '0;
      o_ig_stop_ptr   <= '0;
      o_ig_load_ptr   <= 1'b0;
      o_eg_rdata_clr  <= 1'b0;
      o_eg_rdata_en   <= 1'b0;
      o_eg_rdata_upd  <= 1'b0;
      o_busy          <= 1'b0;
      o_done          <= 1'b0;
      o_pass          <= 1'b0;
      o_err_cnt       <= '0;
      o_first_err_idx <= '1;
      o_timeout       <= 1'b0;
    end else begin
      o_ig_wdata_upd <= 1'b0;
      o_ig_wdata_clr <= 1'b0;
      o_ig_load_ptr  <= 1'b0;
      o_eg_rdata_clr <= 1'b0;
      o_eg_rdata_upd <= 1'b0;
      if (w_start) begin
        r_num           <= w_num;
        r_seed          <= w_seed;
        r_to            <= i_timeout;
        r_lfsr          <= w_seed;
        r_cnt           <= '0;
        o_done          <= 1'b0;
        o_pass          <= 1'b0;
        o_err_cnt       <= '0;
        o_timeout       <= 1'b0;
        o_first_err_idx <= '1;
        o_busy          <= 1'b1;
        o_ig_wdata_clr  <= 1'b1;
        o_eg_rdata_clr  <= 1'b1;
        r_state         <= StClr;
      end else begin
        unique case (r_state)
          StClr: begin
            o_ig_wdata     <= r_lfsr;
            o_ig_wdata_en  <= 1'b1;
            o_ig_wdata_upd <= 1'b1;
            r_state        <= StLoad;
          end
          StLoad: begin
            r_wait  <= '0;
            r_state <= StWrWait;
          end
          StWrWait: begin
            if (i_ig_full && (r_cnt < w_num_m1)) begin
              o_err_cnt     <= r_num;
              o_busy        <= 1'b0;
              o_done        <= 1'b1;
              o_pass        <= 1'b0;
              o_ig_wdata_en <= 1'b0;
              r_state       <= StFail;
            end else if (i_ig_write_done) begin
              r_lfsr <= w_lfsr_nxt;
              r_cnt  <= w_cnt_inc;
              if (w_last) begin
                o_ig_start_ptr <= '0;
                o_ig_stop_ptr  <= w_num_m1[PTR_W-1:0];
                o_ig_load_ptr  <= 1'b1;
                o_ig_wdata_en  <= 1'b0;
                r_lfsr         <= r_seed;
                r_cnt          <= '0;
                r_state        <= StLaunch;
              end else begin
                o_ig_wdata     <= w_lfsr_nxt;
                o_ig_wdata_upd <= 1'b1;
                r_state        <= StLoad;
              end
            end else if (w_wait_hit) begin
              o_timeout     <= 1'b1;
              o_busy        <= 1'b0;
              o_done        <= 1'b1;
              o_pass        <= 1'b0;
              o_ig_wdata_en <= 1'b0;
              r_state       <= StFail;
            end else begin
              r_wait <= r_wait + TO_W'(1);
            end
          end
          StLaunch: begin
            o_eg_rdata_en  <= 1'b1;
            o_eg_rdata_upd <= 1'b1;
            r_state        <= StRdReq;
          end
          StRdReq: begin
            r_wait  <= '0;
            r_state <= StRdWait;
          end
          StRdWait: begin
            if (i_eg_read_done) begin
              o_err_cnt <= w_err_nxt;
              if (w_mismatch && (o_err_cnt == '0)) o_first_err_idx <= r_cnt;
              r_lfsr <= w_lfsr_nxt;
              r_cnt  <= w_cnt_inc;
              if (w_last) begin
                o_busy        <= 1'b0;
                o_done        <= 1'b1;
                o_pass        <= (w_err_nxt == '0);
                o_eg_rdata_en <= 1'b0;
                r_state       <= StDone;
              end else begin
                o_eg_rdata_upd <= 1'b1;
                r_state        <= StRdReq;
              end
            end else if (w_wait_hit) begin
              o_timeout     <= 1'b1;
              o_busy        <= 1'b0;
              o_done        <= 1'b1;
              o_pass        <= 1'b0;
              o_eg_rdata_en <= 1'b0;
              r_state       <= StFail;
            end else begin
              r_wait <= r_wait + TO_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
